eeg_uart_streamer: RTL and testbench
====================================

Name: eeg_uart_streamer

Overview:
- Downstream consumer of the bandpass FIR output.
- Takes the 32-bit filtered accumulator word, scales and saturates it to signed 16 bits, and decimates it.
- Buffers the result in a small FIFO and transmits each sample over a UART 8N1 line as a 3-byte frame (sync, high byte, low byte) to the host PC.
- Sits between dsp_filter and the board TX pin.

Parameters:
- CLK_DIV, 434: clock cycles per UART bit (50 MHz / 115200). Minimum 2.
- DECIM, 4: keep one of every DECIM accepted input samples. 1 = keep all.
- SHIFT, 15: arithmetic right shift applied to filtered_in before saturation. Range 0..16.
- FIFO_DEPTH, 16: sample FIFO depth in 16-bit words. Power of 2, minimum 2.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset. Low = reset.
- filtered_in  in  32  signed filter output word.
- in_valid  in  1  filtered_in is a new sample this cycle. Tie high when the filter runs every clock.
- tx  out  1  UART serial output, idles high.
- busy  out  1  high while a frame is being shifted out.
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently stored.

Behaviour:
- Reset (rst low, asynchronous):
  - tx=1, busy=0, overflow=0, fifo_level=0.
  - Decimation counter=0, FSM=IDLE.
  - FIFO pointers cleared.
  - An in-flight frame is abandoned immediately; no partial bits after release.
- Scaling:
  - s = filtered_in >>> SHIFT, sign-extended.
  - out16 = 32767 if s>32767, -32768 if s<-32768, else s[15:0].
- Decimation:
  - Counter advances only on in_valid and wraps from DECIM-1 to 0.
  - A sample is kept when in_valid=1 and the counter is 0.
  - So the first in_valid after reset is always kept.
- Capture stage:
  - A kept sample is registered (out16 + push strobe) at edge k, where k is the edge that samples in_valid.
  - It is written to the FIFO at edge k+1.
- FIFO:
  - Push when the strobe is set and (not full, or a pop occurs in the same cycle).
  - If full with no pop, the sample is dropped and overflow is set to 1. overflow clears only on reset.
  - Pop only when not empty.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop one word into the frame register, load byte 0 = SYNC_BYTE, go to START, busy=1.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: 8 bits LSB first, each for CLK_DIV cycles.
  - STOP: tx=1 for CLK_DIV cycles. Then, if the byte index is below 2, advance (byte 1 = word[15:8], byte 2 = word[7:0]) and go to START with no idle gap. Otherwise go to IDLE, busy=0.
- Frame timing:
  - A frame lasts 30*CLK_DIV cycles.
  - Back-to-back frames are separated by exactly one IDLE cycle (tx=1, busy=0).
- Latency: with an empty FIFO and FSM in IDLE, in_valid at edge k gives:
  - FIFO write at edge k+1;
  - pop and tx falling to 0 at edge k+2.
- fifo_level reflects the registered FIFO count. The word being transmitted is not counted.
- Bit and byte counters are internal; only tx, busy, overflow and fifo_level are observable.

Test Plan:
1. Reset mid-frame:
   - Stimulus: CLK_DIV=4; drive rst low during the DATA bits of byte 1.
   - Response: tx=1, busy=0, fifo_level=0 in the same cycle. After release, no tx transitions until a new in_valid.
2. Saturation and format, SHIFT=15, DECIM=1:
   - filtered_in=32'h7FFF_FFFF → bytes A5 7F FF.
   - 32'hC000_0000 → A5 80 00.
   - 32'h0001_8000 → A5 00 03.
   - 32'hFFFF_8000 → A5 FF FF.
3. Decimation, DECIM=4:
   - Stimulus: 8 in_valid pulses carrying values 1..8 shifted left by SHIFT.
   - Response: exactly two frames, A5 00 01 and A5 00 05. Pulses with in_valid=0 between them do not advance the counter.
4. Bit timing, CLK_DIV=4, single sample:
   - tx low at edge k+2 for 4 clocks.
   - Data bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), 4 clocks each.
   - Stop bit 4 clocks high; 120 clocks total; busy falls after the final stop bit.
5. Overflow, FIFO_DEPTH=4, CLK_DIV=4:
   - Stimulus: 6 consecutive kept samples.
   - Response: the first is popped into TX, the next 4 fill the FIFO (fifo_level=4), the 6th is dropped with overflow=1.
   - Exactly 5 frames are sent in order; overflow stays 1 afterwards.
6. Full push with pop:
   - Stimulus: FIFO full, new sample strobed in the same cycle as an IDLE pop.
   - Response: sample accepted, fifo_level stays at FIFO_DEPTH, overflow stays 0.

Source files
------------

// File: rtl/eeg_uart_streamer.sv
// Purpose: scale/saturate filtered samples to s16, decimate, buffer, and send as A5/hi/lo UART 8N1 frames.
// Latency: in_valid at edge k -> FIFO write at k+1 -> pop and start bit at k+2 (empty FIFO, idle TX).
// Backpressure: none upstream; kept samples arriving at a full FIFO with no pop are dropped, overflow is sticky.
module eeg_uart_streamer #(
  parameter int          CLK_DIV    = 434,
  parameter int          DECIM      = 4,
  parameter int          SHIFT      = 15,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   filtered_in,
  input  logic                          in_valid,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Scaling and saturation
  logic signed [31:0] w_shifted;
  logic [15:0]        w_sat;
  logic               w_keep;

  // Decimation and capture stage
  logic [DW-1:0]      r_dec_cnt;
  logic               r_cap_vld;
  logic [15:0]        r_cap_dat;

  // Sample FIFO
  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LW-1:0]      r_count;
  logic               r_overflow;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Transmitter
  state_t             r_state, w_state_nxt;
  logic [BW-1:0]      r_baud_cnt, w_baud_nxt;
  logic [2:0]         r_bit_idx, w_bit_nxt;
  logic [1:0]         r_byte_idx, w_byte_nxt;
  logic [15:0]        r_frame, w_frame_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic               r_tx, w_tx_nxt;
  logic               r_busy, w_busy_nxt;
  logic               w_baud_end;

  assign w_shifted = $signed(filtered_in) >>> SHIFT;

  // Clamp the shifted word into the signed 16-bit range
  always_comb begin
    w_sat = w_shifted[15:0];
    if (w_shifted > 32'sd32767) begin
      w_sat = 16'h7FFF;
    end else if (w_shifted < -32'sd32768) begin
      w_sat = 16'h8000;
    end
  end

  // Only a counter value of zero keeps the sample, so the first valid after reset is kept
  assign w_keep = in_valid && (r_dec_cnt == '0);

  // Decimation counter (advances on in_valid only) and one-deep capture register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dec_cnt <= '0;
      r_cap_vld <= 1'b0;
      r_cap_dat <= '0;
    end else begin
      r_cap_vld <= w_keep;
      if (w_keep) begin
        r_cap_dat <= w_sat;
      end
      if (in_valid) begin
        r_dec_cnt <= (r_dec_cnt == DW'(DECIM - 1)) ? '0 : r_dec_cnt + DW'(1);
      end
    end
  end

  assign w_full  = (r_count == LW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // A full FIFO still accepts a word when the transmitter pops in the same cycle
  assign w_push  = r_cap_vld && (!w_full || w_pop);

  // FIFO storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_cap_dat;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
      if (r_cap_vld && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_baud_end = (r_baud_cnt == BW'(CLK_DIV - 1));

  // Transmitter next-state: sync byte, then high byte, then low byte, no gap between bytes
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_idx;
    w_byte_nxt  = r_byte_idx;
    w_frame_nxt = r_frame;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_frame_nxt = r_mem[r_rd_ptr];
          w_shift_nxt = SYNC_BYTE;
          w_byte_nxt  = 2'd0;
          w_baud_nxt  = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud_cnt + BW'(1);
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + BW'(1);
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_byte_idx < 2'd2) begin
            w_byte_nxt  = r_byte_idx + 2'd1;
            w_shift_nxt = (r_byte_idx == 2'd0) ? r_frame[15:8] : r_frame[7:0];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + BW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_tx_nxt   = (w_state_nxt == S_START) ? 1'b0 :
                 (w_state_nxt == S_DATA)  ? w_shift_nxt[0] : 1'b1;
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Transmitter state and registered line outputs; reset abandons any frame at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_frame    <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_byte_idx <= w_byte_nxt;
      r_frame    <= w_frame_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign overflow   = r_overflow;
  assign fifo_level = r_count;

endmodule

// File: tb/tb_eeg_uart_streamer.sv
// Purpose: bench for eeg_uart_streamer; two instances (DECIM=1/depth 4 and DECIM=4/depth 16), CLK_DIV=4.
// Latency: UART receivers rebuild bytes from tx and compare them against a frame-level model.
// Backpressure: not applicable; overflow and full-with-pop cases are driven directly.
module tb_eeg_uart_streamer;

  localparam int CD    = 4;
  localparam int SHIFT = 15;
  localparam int DA    = 1;
  localparam int DB    = 4;

  logic        clk;
  logic        rst;
  logic [31:0] filtered_in_a, filtered_in_b;
  logic        in_valid_a, in_valid_b;
  logic        tx_a, tx_b, busy_a, busy_b, ovf_a, ovf_b;
  logic [2:0]  lvl_a;
  logic [4:0]  lvl_b;

  int          n_checks;
  int          n_fail;
  int          vcnt_b;

  logic [7:0]  rx_a[$], rx_b[$], exp_a[$], exp_b[$];
  logic        wave[120];

  eeg_uart_streamer #(.CLK_DIV(CD), .DECIM(DA), .SHIFT(SHIFT), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .filtered_in(filtered_in_a), .in_valid(in_valid_a),
    .tx(tx_a), .busy(busy_a), .overflow(ovf_a), .fifo_level(lvl_a));

  eeg_uart_streamer #(.CLK_DIV(CD), .DECIM(DB), .SHIFT(SHIFT), .FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .filtered_in(filtered_in_b), .in_valid(in_valid_b),
    .tx(tx_b), .busy(busy_b), .overflow(ovf_b), .fifo_level(lvl_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Floor division by 2^SHIFT, then clamp to the signed 16-bit range
  function automatic logic [15:0] sat16(input logic [31:0] v);
    longint sv, d, q;
    sv = longint'($signed(v));
    d  = longint'(1) << SHIFT;
    if (sv >= 0) q = sv / d;
    else         q = -((-sv + d - 1) / d);
    if (q > 32767)       q = 32767;
    else if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic exp_bytes(input int sel, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    if (sel == 0) begin exp_a.push_back(b0); exp_a.push_back(b1); exp_a.push_back(b2); end
    else          begin exp_b.push_back(b0); exp_b.push_back(b1); exp_b.push_back(b2); end
  endtask

  task automatic exp_sample(input int sel, input logic [31:0] v);
    logic [15:0] w;
    w = sat16(v);
    exp_bytes(sel, 8'hA5, w[15:8], w[7:0]);
  endtask

  // UART 8N1 receiver: called half a clock into the start bit, samples mid-bit
  task automatic uart_rx(input int sel, output logic [7:0] b, output logic stop);
    repeat (CD / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CD) @(negedge clk);
      b[i] = (sel == 0) ? tx_a : tx_b;
    end
    repeat (CD) @(negedge clk);
    stop = (sel == 0) ? tx_a : tx_b;
  endtask

  always begin : mon_a
    logic [7:0] b;
    logic       s;
    @(negedge clk);
    if (rst === 1'b1 && tx_a === 1'b0) begin
      uart_rx(0, b, s);
      rx_a.push_back(b);
      chk("stop_bit_a", 32'(s), 32'd1);
    end
  end

  always begin : mon_b
    logic [7:0] b;
    logic       s;
    @(negedge clk);
    if (rst === 1'b1 && tx_b === 1'b0) begin
      uart_rx(1, b, s);
      rx_b.push_back(b);
      chk("stop_bit_b", 32'(s), 32'd1);
    end
  end

  // Each step drives inputs at a negedge; the following posedge samples them
  task automatic step_a(input logic v, input logic [31:0] d);
    in_valid_a    = v;
    filtered_in_a = d;
    @(negedge clk);
  endtask

  task automatic step_b(input logic v, input logic [31:0] d);
    in_valid_b    = v;
    filtered_in_b = d;
    @(negedge clk);
  endtask

  task automatic clear_q();
    rx_a.delete(); rx_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    vcnt_b = 0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int sel, input string tag);
    int t;
    logic bz;
    int lv;
    t = 0;
    repeat (4) @(negedge clk);
    bz = (sel == 0) ? busy_a : busy_b;
    lv = (sel == 0) ? int'(lvl_a) : int'(lvl_b);
    while (t < 8000 && (bz !== 1'b0 || lv != 0)) begin
      @(negedge clk);
      t++;
      bz = (sel == 0) ? busy_a : busy_b;
      lv = (sel == 0) ? int'(lvl_a) : int'(lvl_b);
    end
    chk({tag, "_drained"}, {bz, 31'(lv)}, 32'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic cmp_q(input int sel, input string tag);
    logic [7:0] r[$];
    logic [7:0] e[$];
    if (sel == 0) begin r = rx_a; e = exp_a; end
    else          begin r = rx_b; e = exp_b; end
    chk({tag, "_len"}, 32'(r.size()), 32'(e.size()));
    for (int i = 0; i < r.size() && i < e.size(); i++) begin
      chk({tag, "_byte"}, 32'(r[i]), 32'(e[i]));
    end
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = (($urandom & 32'h0000_FFFF) << 15) | ($urandom & 32'h7FFF);
      1:       v = ~((($urandom & 32'h0000_FFFF) << 15) | ($urandom & 32'h7FFF));
      2:       v = (($urandom & 32'h0000_7FFF) << 15) | ($urandom & 32'h7FFF);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [7:0]  fb[3];
    logic [31:0] sv[6];
    int          idx;
    int          errs;
    int          nv;
    logic        v;
    logic [31:0] d;

    n_checks = 0; n_fail = 0; vcnt_b = 0;
    rst = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    filtered_in_a = '0; filtered_in_b = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_tx_a", 32'(tx_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_lvl_a", 32'(lvl_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    chk("rst_lvl_b", 32'(lvl_b), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset during the data bits of byte 1
    step_a(1'b1, 32'h0001_8000);
    step_a(1'b1, 32'h0002_0000);
    repeat (52) step_a(1'b0, $urandom);
    chk("mid_busy", 32'(busy_a), 32'd1);
    chk("mid_lvl", 32'(lvl_a), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx", 32'(tx_a), 32'd1);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_lvl", 32'(lvl_a), 32'd0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) errs++;
    end
    chk("post_rst_quiet", 32'(errs), 32'd0);
    clear_q();

    // Saturation and byte format
    sv[0] = 32'h7FFF_FFFF; sv[1] = 32'hC000_0000; sv[2] = 32'h0001_8000; sv[3] = 32'hFFFF_8000;
    exp_bytes(0, 8'hA5, 8'h7F, 8'hFF);
    exp_bytes(0, 8'hA5, 8'h80, 8'h00);
    exp_bytes(0, 8'hA5, 8'h00, 8'h03);
    exp_bytes(0, 8'hA5, 8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, sv[i]);
      repeat (130) step_a(1'b0, $urandom);
    end
    wait_drain(0, "sat");
    cmp_q(0, "sat");
    clear_q();

    // Bit timing of a single frame
    fb[0] = 8'hA5; fb[1] = 8'h00; fb[2] = 8'h03;
    idx = 0;
    for (int j = 0; j < 3; j++) begin
      for (int c = 0; c < CD; c++) begin wave[idx] = 1'b0; idx++; end
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < CD; c++) begin wave[idx] = fb[j][b]; idx++; end
      for (int c = 0; c < CD; c++) begin wave[idx] = 1'b1; idx++; end
    end
    exp_sample(0, 32'h0001_8000);
    step_a(1'b1, 32'h0001_8000);
    step_a(1'b0, 32'h0);
    chk("lat_k1_lvl", 32'(lvl_a), 32'd1);
    chk("lat_k1_tx", 32'(tx_a), 32'd1);
    errs = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx_a !== wave[i] || busy_a !== 1'b1) errs++;
      if (i == 0) chk("lat_k2_lvl", 32'(lvl_a), 32'd0);
    end
    chk("frame_wave", 32'(errs), 32'd0);
    @(negedge clk);
    chk("frame_end_busy", 32'(busy_a), 32'd0);
    chk("frame_end_tx", 32'(tx_a), 32'd1);
    wait_drain(0, "timing");
    cmp_q(0, "timing");
    clear_q();

    // Overflow on a burst of six kept samples
    for (int i = 0; i < 6; i++) sv[i] = rnd_val();
    for (int i = 0; i < 5; i++) exp_sample(0, sv[i]);
    for (int i = 0; i < 6; i++) step_a(1'b1, sv[i]);
    chk("ovf_lvl_full", 32'(lvl_a), 32'd4);
    chk("ovf_before", 32'(ovf_a), 32'd0);
    step_a(1'b0, 32'h0);
    chk("ovf_lvl_after", 32'(lvl_a), 32'd4);
    chk("ovf_set", 32'(ovf_a), 32'd1);
    wait_drain(0, "ovf");
    cmp_q(0, "ovf");
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    do_reset();
    chk("ovf_cleared", 32'(ovf_a), 32'd0);
    clear_q();

    // Full FIFO accepts a sample in the cycle the idle transmitter pops
    for (int i = 0; i < 6; i++) begin sv[i] = rnd_val(); exp_sample(0, sv[i]); end
    for (int i = 0; i < 5; i++) step_a(1'b1, sv[i]);
    repeat (117) step_a(1'b0, $urandom);
    chk("fp_lvl_pre", 32'(lvl_a), 32'd4);
    step_a(1'b1, sv[5]);
    chk("fp_idle_busy", 32'(busy_a), 32'd0);
    step_a(1'b0, 32'h0);
    chk("fp_lvl", 32'(lvl_a), 32'd4);
    chk("fp_ovf", 32'(ovf_a), 32'd0);
    chk("fp_busy", 32'(busy_a), 32'd1);
    wait_drain(0, "fullpop");
    cmp_q(0, "fullpop");
    chk("fp_ovf_end", 32'(ovf_a), 32'd0);
    clear_q();

    // Decimation by 4: values 1..8, idle cycles in between carry junk
    exp_bytes(1, 8'hA5, 8'h00, 8'h01);
    exp_bytes(1, 8'hA5, 8'h00, 8'h05);
    for (int n = 1; n <= 8; n++) begin
      step_b(1'b1, 32'(n) << SHIFT);
      repeat ($urandom_range(0, 3)) step_b(1'b0, $urandom);
    end
    step_b(1'b0, 32'h0);
    wait_drain(1, "decim");
    cmp_q(1, "decim");
    do_reset();
    clear_q();

    // Random stream through the decimating instance
    nv = 0;
    for (int i = 0; i < 250; i++) begin
      v = ($urandom_range(0, 3) == 0) && (nv < 64);
      d = rnd_val();
      if (v) begin
        if (vcnt_b % DB == 0) exp_sample(1, d);
        vcnt_b++;
        nv++;
      end
      step_b(v, d);
    end
    repeat (3) step_b(1'b0, 32'h0);
    wait_drain(1, "rand_b");
    cmp_q(1, "rand_b");
    chk("rand_b_ovf", 32'(ovf_b), 32'd0);

    // Random spaced samples through the non-decimating instance
    for (int i = 0; i < 8; i++) begin
      d = rnd_val();
      exp_sample(0, d);
      step_a(1'b1, d);
      repeat ($urandom_range(125, 180)) step_a(1'b0, $urandom);
    end
    wait_drain(0, "rand_a");
    cmp_q(0, "rand_a");
    chk("rand_a_ovf", 32'(ovf_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
